// File: rtl/baud_tick_gen.sv
// Purpose  : baud tick generator; turns the divisor K (clocks per bit) into
//            a one-cycle bit-period tick and a one-cycle mid-bit half_tick.
// Latency  : outputs are registered. The first tick appears on the K-th edge
//            that samples en=1 after idle; after that, one tick every K clocks.
// Backpress: none. This is a free-running timebase. en and restart are the
//            only controls, and consumers must take each pulse in its cycle.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   K          divisor from the baud decoder (clocks per bit)
//   en         run the counter; low = idle, with the counter held at 0
//   restart    resync pulse (RX start-bit edge / TX load)
//   tick       1-cycle pulse at the end of each bit period
//   half_tick  1-cycle pulse at mid-bit (floor(k/2)-th clock of the period)
//   k_err      set while the last loaded K was below 2 (the divisor was clamped)
//   tick_count only with BAUD_TICK_COUNT_EN: ticks since the last load,
//              saturating at 15 (bit index for the frame shifter)
//
// Build option: define BAUD_TICK_COUNT_EN to add the tick_count output.
module baud_tick_gen #(
  parameter int             K_W   = 19,
  parameter logic [K_W-1:0] K_RST = K_W'(333333)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [K_W-1:0] K,
  input  logic           en,
  input  logic           restart,
  output logic           tick,
  output logic           half_tick,
  output logic           k_err
`ifdef BAUD_TICK_COUNT_EN
  ,
  output logic [3:0]     tick_count
`endif
);

  localparam logic [K_W-1:0] ONE = K_W'(1);
  localparam logic [K_W-1:0] TWO = K_W'(2);

  logic [K_W-1:0] cnt;
  logic [K_W-1:0] k_q;

  logic           load;
  logic           k_small;
  logic [K_W-1:0] k_clamped;
  logic [K_W-1:0] end_cnt;
  logic [K_W-1:0] mid_cnt;
  logic           at_end;
  logic           at_mid;

  // A load happens on any edge that is not a plain counting edge: idle
  // (en low) or a resync. On a load edge, the divisor is captured and the
  // period restarts from zero. While counting, K is not sampled, so the
  // decoder can change it freely without disturbing the current frame.
  always_comb begin
    load      = 1'b0;
    k_small   = 1'b0;
    k_clamped = K;
    end_cnt   = '0;
    mid_cnt   = '0;
    at_end    = 1'b0;
    at_mid    = 1'b0;

    load    = !en || restart;
    k_small = (K < TWO);

    // Clamp to 2 so that end_cnt and mid_cnt below can never wrap.
    if (k_small) begin
      k_clamped = TWO;
    end

    end_cnt = k_q - ONE;
    mid_cnt = (k_q >> 1) - ONE;

    // end_cnt > mid_cnt whenever k_q >= 2, so the two never coincide.
    at_end = (cnt == end_cnt);
    at_mid = (cnt == mid_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      k_q       <= K_RST;
      tick      <= 1'b0;
      half_tick <= 1'b0;
      k_err     <= 1'b0;
    end else if (load) begin
      // Restart wins over a coinciding terminal count: no tick this edge.
      cnt       <= '0;
      k_q       <= k_clamped;
      tick      <= 1'b0;
      half_tick <= 1'b0;
      k_err     <= k_small;
    end else begin
      tick      <= at_end;
      half_tick <= at_mid;
      if (at_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

`ifdef BAUD_TICK_COUNT_EN
  // Counts alongside tick: the count goes up on the same edge that raises tick.
  // The shifter therefore sees the index of the bit that just completed
  // together with the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_count <= 4'd0;
    end else if (load) begin
      tick_count <= 4'd0;
    end else if (at_end && (tick_count != 4'd15)) begin
      tick_count <= tick_count + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

  localparam int             K_W      = 19;
  // The reset divisor is reduced here so that the post-reset run stays short.
  localparam logic [K_W-1:0] K_RST_TB = 19'd1001;

  logic           clk = 1'b0;
  logic           reset;
  logic [K_W-1:0] K;
  logic           en;
  logic           restart;
  logic           tick;
  logic           half_tick;
  logic           k_err;
`ifdef BAUD_TICK_COUNT_EN
  logic [3:0]     tick_count;
`endif

  baud_tick_gen #(.K_W(K_W), .K_RST(K_RST_TB)) dut (
    .clk       (clk),
    .reset     (reset),
    .K         (K),
    .en        (en),
    .restart   (restart),
    .tick      (tick),
    .half_tick (half_tick),
    .k_err     (k_err)
`ifdef BAUD_TICK_COUNT_EN
    ,
    .tick_count(tick_count)
`endif
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; it is stable when read at a falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    bit is_tick;
  } ev_t;
  ev_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int at, input bit is_tick);
    ev_t e;
    e.at      = at;
    e.is_tick = is_tick;
    exp_q.push_back(e);
  endtask

  // Expected pulses for n full periods of k clocks. The periods start at base,
  // where base is the cycle of the falling edge at which en was raised.
  task automatic push_periods(input int base, input int k, input int n);
    for (int i = 0; i < n; i++) begin
      push(base + i * k + k / 2, 1'b0);
      push(base + (i + 1) * k, 1'b1);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Present K for one idle edge (a load edge), then check k_err. The task
  // returns the cycle stamp at which the caller raises en.
  task automatic start_run(input logic [K_W-1:0] k, input bit exp_err, output int c);
    K       = k;
    en      = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    check("k_err_after_load", {31'b0, k_err}, {31'b0, exp_err});
    c = cyc;
  endtask

  task automatic drained(input string nm);
    @(negedge clk);
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: each pulse the DUT produces is matched against the next expected pulse.
  always @(negedge clk) begin
    ev_t e;
    if (tick === 1'b1 || half_tick === 1'b1) begin
      check("tick_half_exclusive", {31'b0, tick & half_tick}, 0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: tick=%0b half_tick=%0b at cycle %0d, none required",
                 tick, half_tick, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_kind_is_tick", {31'b0, tick}, {31'b0, e.is_tick});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int r;
    reset   = 1'b1;
    en      = 1'b0;
    restart = 1'b0;
    K       = 19'd4;
    #1 reset = 1'b0;
    #10;
    check("reset_tick", {31'b0, tick}, 0);
    check("reset_half_tick", {31'b0, half_tick}, 0);
    check("reset_k_err", {31'b0, k_err}, 0);
`ifdef BAUD_TICK_COUNT_EN
    check("reset_tick_count", {28'b0, tick_count}, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // K=4: half_tick on edges 2,6,10 and tick on edges 4,8,12.
    start_run(19'd4, 1'b0, c);
    en = 1'b1;
    push(c + 2, 1'b0); push(c + 4, 1'b1);
    push(c + 6, 1'b0); push(c + 8, 1'b1);
    push(c + 10, 1'b0); push(c + 12, 1'b1);
    wait_until(c + 12);
    en = 1'b0;
    drained("k4_all_pulses_seen");

    // K=5 (odd): half_tick at floor(5/2)=2, then a tick every 5 clocks.
    start_run(19'd5, 1'b0, c);
    en = 1'b1;
    push_periods(c, 5, 3);
    wait_until(c + 15);
    en = 1'b0;
    drained("k5_all_pulses_seen");

    // K=0 and K=1 are clamped to 2 and set k_err.
    start_run(19'd0, 1'b1, c);
    en = 1'b1;
    push_periods(c, 2, 3);
    wait_until(c + 6);
    en = 1'b0;
    drained("k0_all_pulses_seen");

    start_run(19'd1, 1'b1, c);
    en = 1'b1;
    push_periods(c, 2, 3);
    wait_until(c + 6);
    check("k_err_holds_while_running", {31'b0, k_err}, 1);
    en = 1'b0;
    drained("k1_all_pulses_seen");

    // Reloading with K=8 clears k_err. A restart at cnt=7 suppresses the tick.
    start_run(19'd8, 1'b0, c);
    en = 1'b1;
    push(c + 4, 1'b0);
    wait_until(c + 7);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    push_periods(c + 8, 8, 1);
    wait_until(c + 16);
    en = 1'b0;
    drained("restart_all_pulses_seen");

    // K changed while running is ignored until the next idle edge.
    start_run(19'd4, 1'b0, c);
    en = 1'b1;
    push_periods(c, 4, 3);
    @(negedge clk);
    K = 19'd10;
    wait_until(c + 12);
    en = 1'b0;
    drained("k_change_ignored");
    start_run(19'd10, 1'b0, c);
    en = 1'b1;
    push_periods(c, 10, 2);
    wait_until(c + 20);
    en = 1'b0;
    drained("k10_after_reload");

    // Asynchronous reset clears outputs at once, with no clock edge needed.
    start_run(19'd1, 1'b1, c);
    en = 1'b1;
    push(c + 1, 1'b0);
    wait_until(c + 1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_half_tick", {31'b0, half_tick}, 0);
    check("async_reset_k_err", {31'b0, k_err}, 0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drained("async_reset_queue");

    // Reset at cnt=3 of K=10. Release with en=1 and no load, so k_q=K_RST.
    start_run(19'd10, 1'b0, c);
    en = 1'b1;
    wait_until(c + 3);
    reset = 1'b0;
    #1;
    check("reset_mid_tick", {31'b0, tick}, 0);
    check("reset_mid_half_tick", {31'b0, half_tick}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    r = cyc;
    push(r + 500, 1'b0);
    push(r + 1001, 1'b1);
    wait_until(r + 1001);
    en = 1'b0;
    drained("krst_first_tick");

`ifdef BAUD_TICK_COUNT_EN
    start_run(19'd3, 1'b0, c);
    check("tick_count_cleared", {28'b0, tick_count}, 0);
    en = 1'b1;
    push_periods(c, 3, 20);
    wait_until(c + 42);
    check("tick_count_14", {28'b0, tick_count}, 14);
    wait_until(c + 45);
    check("tick_count_15", {28'b0, tick_count}, 15);
    wait_until(c + 60);
    check("tick_count_saturated", {28'b0, tick_count}, 15);
    en = 1'b0;
    drained("tick_count_pulses_seen");
    check("tick_count_cleared_on_load", {28'b0, tick_count}, 0);
`endif

    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
